// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline-control slice.
//   state_t     : hazard controller FSM states (RUN, REDIRECT)
//   NOP_INSTR   : encoding loaded into IF/ID on a flush (addi x0, x0, 0)
//   XLEN_DEF    : default address/PC width
//   REG_ADDR_W_DEF : default register-index width
//   CNT_W_DEF   : default performance-counter width
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          XLEN_DEF       = 32;
  localparam int          REG_ADDR_W_DEF = 5;
  localparam int          CNT_W_DEF      = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Enable-driven performance counter that wraps modulo 2^W.
// Ports:
//   clk   : core clock
//   rst_n : synchronous active-low reset, clears the count
//   en    : count this cycle
//   cnt   : current count
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      // Natural overflow gives the wrap; no saturation.
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline-control block for the 5-stage core.
// Drives stall/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, detects
// load-use hazards, sequences taken-branch redirects to fetch and freezes
// the pipeline while data memory is busy. Keeps stall and redirect counters.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   id_rs1/id_rs2         : source registers of the ID instruction
//   id_use_rs1/id_use_rs2 : ID instruction actually reads that source
//   ex_mem_read, ex_rd    : EX instruction is a load, and its destination
//   ex_branch_taken       : one-cycle pulse, EX branch resolved taken
//   ex_branch_target      : target for that branch
//   dmem_busy             : data memory not done this cycle (freeze)
//   redirect_ready        : fetch accepts the redirect this cycle
//   redirect_valid/pc     : redirect request and target to fetch
//   pc_stall .. mem_wb_flush : per-register stall/flush controls
//   stall_cnt             : cycles with pc_stall=1
//   redirect_cnt          : redirects accepted
//   state_dbg             : current FSM state (0=RUN, 1=REDIRECT)
//
// Redirect handshake: a redirect transfers on any cycle where
// redirect_valid and redirect_ready are both 1. Once redirect_valid rises
// it stays high, with redirect_pc stable, until that transfer happens
// (the only exception is reset). redirect_pc is 0 while redirect_valid=0.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic [XLEN-1:0]       ex_branch_target,
  input  logic                  dmem_busy,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_flush,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      redirect_cnt,
  output logic                  state_dbg
);

  state_t          state;
  logic [XLEN-1:0] pend_target;

  logic freeze;
  logic load_use;
  logic redirect_fire;

  assign freeze = dmem_busy;

  // A load into x0 never creates a real dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign redirect_fire = redirect_valid && redirect_ready;
  assign state_dbg     = state;

  // Control outputs. Priority: freeze > redirect > load-use.
  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_stall   = 1'b0;
    mem_wb_flush   = 1'b0;

    if (freeze) begin
      // Hold everything upstream of MEM; MEM/WB gets a bubble so the
      // stalled memory op does not retire twice.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end

    if (state == REDIRECT) begin
      // Keep presenting the pending redirect even while frozen; fetch
      // gives the redirect priority over pc_stall.
      redirect_valid = 1'b1;
      redirect_pc    = pend_target;
      if (!freeze) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    end else if (!freeze && ex_branch_taken) begin
      redirect_valid = 1'b1;
      redirect_pc    = ex_branch_target;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
    end else if (!freeze && load_use) begin
      // One bubble: the load moves to MEM next cycle so the hazard clears.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pend_target <= '0;
    end else begin
      case (state)
        RUN: begin
          // A branch under freeze is not presented this cycle; park it.
          if (ex_branch_taken && (freeze || !redirect_ready)) begin
            pend_target <= ex_branch_target;
            state       <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_stall),
    .cnt   (stall_cnt)
  );

  hazard_perf_cnt #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (redirect_fire),
    .cnt   (redirect_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic                  id_use_rs1, id_use_rs2, ex_mem_read;
  logic                  ex_branch_taken, dmem_busy, redirect_ready;
  logic [XLEN-1:0]       ex_branch_target;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush, state_dbg;
  logic [CNT_W-1:0]      stall_cnt, redirect_cnt;

  hazard_ctrl #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .dmem_busy        (dmem_busy),
    .redirect_ready   (redirect_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .pc_stall         (pc_stall),
    .if_id_stall      (if_id_stall),
    .if_id_flush      (if_id_flush),
    .id_ex_stall      (id_ex_stall),
    .id_ex_flush      (id_ex_flush),
    .ex_mem_stall     (ex_mem_stall),
    .mem_wb_flush     (mem_wb_flush),
    .stall_cnt        (stall_cnt),
    .redirect_cnt     (redirect_cnt),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 ns after a rising edge; outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0;
    ex_branch_target = '0; dmem_busy = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Pack the control outputs: {pc,if_id_s,if_id_f,id_ex_s,id_ex_f,ex_mem_s,mem_wb_f}
  function automatic logic [6:0] ctl();
    return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
            ex_mem_stall, mem_wb_flush};
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    settle();
    check("rst_state", state_dbg, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_redir_cnt", redirect_cnt, 0);
    check("rst_valid", redirect_valid, 0);
    check("rst_ctl", ctl(), 7'b0000000);

    // Load-use on rs1
    tick();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    settle();
    check("lu_rs1_ctl", ctl(), 7'b1100100);
    check("lu_rs1_valid", redirect_valid, 0);
    tick();
    check("lu_rs1_cnt", stall_cnt, 1);
    idle();
    settle();
    check("lu_clear_ctl", ctl(), 7'b0000000);
    // ex_rd = 0: no hazard
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    settle();
    check("lu_x0_ctl", ctl(), 7'b0000000);
    tick();
    check("lu_x0_cnt", stall_cnt, 1);
    // Load-use on rs2, then same regs but rs2 not used
    idle();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    settle();
    check("lu_rs2_ctl", ctl(), 7'b1100100);
    tick();
    check("lu_rs2_cnt", stall_cnt, 2);
    id_use_rs2 = 0;
    settle();
    check("lu_nouse_ctl", ctl(), 7'b0000000);
    // Not a load: no hazard
    id_use_rs2 = 1; ex_mem_read = 0;
    settle();
    check("lu_noload_ctl", ctl(), 7'b0000000);

    // Branch with immediate acceptance
    idle();
    ex_branch_taken = 1; ex_branch_target = 32'h80; redirect_ready = 1;
    settle();
    check("br_rdy_valid", redirect_valid, 1);
    check("br_rdy_pc", redirect_pc, 32'h80);
    check("br_rdy_ctl", ctl(), 7'b0010100);
    tick();
    check("br_rdy_cnt", redirect_cnt, 1);
    check("br_rdy_state", state_dbg, 0);
    idle();
    settle();
    check("br_idle_valid", redirect_valid, 0);
    check("br_idle_pc", redirect_pc, 0);

    // Branch with back-pressure: ready low 3 cycles, then high
    ex_branch_taken = 1; ex_branch_target = 32'h100; redirect_ready = 0;
    settle();
    check("bp_c1_pc", redirect_pc, 32'h100);
    check("bp_c1_ctl", ctl(), 7'b0010100);
    tick();
    check("bp_state", state_dbg, 1);
    ex_branch_taken = 0; ex_branch_target = 32'hdead;
    // load-use inputs must be ignored in REDIRECT
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    settle();
    check("bp_c2_valid", redirect_valid, 1);
    check("bp_c2_pc", redirect_pc, 32'h100);
    check("bp_c2_ctl", ctl(), 7'b0010100);
    tick();
    idle();
    ex_branch_taken = 1; ex_branch_target = 32'h444; // ignored in REDIRECT
    settle();
    check("bp_c3_pc", redirect_pc, 32'h100);
    check("bp_c3_ctl", ctl(), 7'b0010100);
    tick();
    idle();
    redirect_ready = 1;
    settle();
    check("bp_c4_valid", redirect_valid, 1);
    check("bp_c4_pc", redirect_pc, 32'h100);
    check("bp_c4_ctl", ctl(), 7'b0010100);
    tick();
    check("bp_ret_state", state_dbg, 0);
    check("bp_redir_cnt", redirect_cnt, 2);
    check("bp_stall_cnt", stall_cnt, 2);

    // Freeze + branch
    idle();
    dmem_busy = 1; ex_branch_taken = 1; ex_branch_target = 32'h200;
    redirect_ready = 1;
    settle();
    check("fz_c1_ctl", ctl(), 7'b1101011);
    check("fz_c1_valid", redirect_valid, 0);
    check("fz_c1_pc", redirect_pc, 0);
    tick();
    check("fz_c1_cnt", redirect_cnt, 2);
    check("fz_state", state_dbg, 1);
    ex_branch_taken = 0; ex_branch_target = 0; redirect_ready = 0;
    settle();
    check("fz_c2_valid", redirect_valid, 1);
    check("fz_c2_pc", redirect_pc, 32'h200);
    check("fz_c2_ctl", ctl(), 7'b1101011);
    tick();
    check("fz_stall_cnt", stall_cnt, 4);
    dmem_busy = 0; redirect_ready = 1;
    settle();
    check("fz_c3_ctl", ctl(), 7'b0010100);
    check("fz_c3_pc", redirect_pc, 32'h200);
    tick();
    check("fz_ret_state", state_dbg, 0);
    check("fz_redir_cnt", redirect_cnt, 3);

    // Freeze in REDIRECT with ready high: handshake completes under freeze
    idle();
    ex_branch_taken = 1; ex_branch_target = 32'h280; redirect_ready = 0;
    tick();
    ex_branch_taken = 0; dmem_busy = 1; redirect_ready = 1;
    settle();
    check("fzr_valid", redirect_valid, 1);
    check("fzr_ctl", ctl(), 7'b1101011);
    tick();
    check("fzr_state", state_dbg, 0);
    check("fzr_redir_cnt", redirect_cnt, 4);
    check("fzr_stall_cnt", stall_cnt, 5);

    // Simultaneous load-use + branch: branch wins
    idle();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    ex_branch_taken = 1; ex_branch_target = 32'h300; redirect_ready = 1;
    settle();
    check("lub_ctl", ctl(), 7'b0010100);
    check("lub_valid", redirect_valid, 1);
    check("lub_pc", redirect_pc, 32'h300);
    tick();
    check("lub_redir_cnt", redirect_cnt, 5);
    check("lub_stall_cnt", stall_cnt, 5);

    // Reset while in REDIRECT
    idle();
    ex_branch_taken = 1; ex_branch_target = 32'h400; redirect_ready = 0;
    tick();
    idle();
    check("rr_state_pre", state_dbg, 1);
    rst_n = 0;
    #2;
    check("rr_async_state", state_dbg, 1);
    check("rr_async_cnt", redirect_cnt, 5);
    tick();
    check("rr_state", state_dbg, 0);
    check("rr_valid", redirect_valid, 0);
    check("rr_pc", redirect_pc, 0);
    check("rr_stall_cnt", stall_cnt, 0);
    check("rr_redir_cnt", redirect_cnt, 0);
    rst_n = 1;
    redirect_ready = 1;
    settle();
    check("rr_post_valid", redirect_valid, 0);
    tick();
    check("rr_post_cnt", redirect_cnt, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central pipeline-control block for the 5-stage core. It drives stall and flush for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and detects load-use hazards. It sequences taken-branch redirects to fetch over a valid/ready handshake and freezes the pipeline while data memory is busy. It also keeps stall and redirect performance counters.

Parameters:
XLEN, 32, address/PC width
REG_ADDR_W, 5, register index width
CNT_W, 32, perf counter width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_ADDR_W  EX destination register
ex_branch_taken  in  1  one-cycle pulse: EX branch/jump resolved taken
ex_branch_target  in  XLEN  target for ex_branch_taken
dmem_busy  in  1  data memory not done this cycle
redirect_ready  in  1  fetch unit accepts redirect this cycle
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  XLEN  redirect target
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP (0x00000013) into IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  load bubble into MEM/WB
stall_cnt  out  CNT_W  cycles with pc_stall=1
redirect_cnt  out  CNT_W  redirects accepted

Behaviour:
- Single clock `clk`. Reset is synchronous and active-low on `rst_n`, sampled at posedge `clk`.
- Reset state: FSM=RUN, pend_target=0, stall_cnt=0, redirect_cnt=0. A reset mid-REDIRECT drops the pending target.
- FSM states: RUN, REDIRECT. All control outputs are combinational from state and inputs.
- Priority per cycle: freeze > redirect > load-use.
- freeze = dmem_busy.
  - Outputs: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1; if_id_flush = id_ex_flush = 0.
  - Freeze in REDIRECT: redirect_valid stays 1 and the handshake may complete. Fetch gives redirect priority over pc_stall.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Applies only in RUN, not frozen, no ex_branch_taken.
  - Outputs: pc_stall = if_id_stall = 1, id_ex_flush = 1. Exactly one bubble; the hazard clears the next cycle by construction.
- RUN with ex_branch_taken and not frozen:
  - redirect_valid = 1, redirect_pc = ex_branch_target, if_id_flush = id_ex_flush = 1.
  - redirect_ready = 1: accept; redirect_cnt += 1; stay RUN.
  - redirect_ready = 0: latch pend_target <= ex_branch_target; go to REDIRECT.
- RUN with ex_branch_taken and frozen:
  - Latch pend_target and go to REDIRECT. No redirect is presented that cycle.
- REDIRECT:
  - redirect_valid = 1, redirect_pc = pend_target.
  - If not frozen: if_id_flush = id_ex_flush = 1 every cycle, to squash wrong-path fetches.
  - On redirect_ready = 1: redirect_cnt += 1, go to RUN.
  - ex_branch_taken is ignored here; EX holds a bubble.
  - load_use is ignored here.
- redirect_pc = 0 whenever redirect_valid = 0.
- Counters increment by 1 per qualifying cycle and wrap modulo 2^CNT_W. No saturation.
- stall_cnt counts every cycle where pc_stall = 1, from both freeze and load-use.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state enum {RUN, REDIRECT}
  - NOP_INSTR = 32'h00000013
  - XLEN / REG_ADDR_W defaults
- Sub-module `hazard_perf_cnt`: an enable-driven wrapping counter, instantiated twice.
- Hazard compare and FSM stay in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cnt 0->1. Repeat with ex_rd=0 -> no stall.
- Branch, ready: ex_branch_taken=1, target=0x80, redirect_ready=1 -> redirect_valid=1, redirect_pc=0x80, if_id_flush=id_ex_flush=1 for one cycle; redirect_cnt=1; FSM stays RUN.
- Branch, back-pressure: target=0x100, redirect_ready=0 for 3 cycles then 1 -> redirect_valid and flushes held 4 cycles with redirect_pc=0x100; FSM returns to RUN; redirect_cnt +1.
- Freeze + branch: dmem_busy=1 for 2 cycles with ex_branch_taken pulse in cycle 1 -> all stalls=1, mem_wb_flush=1, redirect_valid=0 in cycle 1, redirect_valid=1 with pend_target from cycle 2; stall_cnt +2.
- Simultaneous load-use + branch -> branch wins: id_ex_flush=1, pc_stall=0, redirect issued.
- rst_n=0 asserted while in REDIRECT -> next cycle FSM=RUN, redirect_valid=0, counters=0; asserting rst_n without a clk edge does not reset.
